// File: rtl/coredata_initiator.sv
// coredata_initiator: turns a block-transfer command plus a write stream into
// core data bus word requests, and returns read responses as a stream.
// Ports:
//   cmd_*            command handshake (addr, len in words, we)
//   wr_*             write-data stream in; rd_* read-data stream out
//   req/gnt/rvalid   core data bus (addr_o, we_o, be_o, wdata_o, rdata_i)
//   busy_o/done_o    status; err_o is the sticky stray-response flag
//   stall_cnt_o      req-without-gnt cycles when COREDATA_INIT_STATS_EN is
//                    defined, otherwise tied to 0
module coredata_initiator #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int LEN_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic [31:0]      cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             cmd_we_i,
  input  logic             wr_valid_i,
  output logic             wr_ready_o,
  input  logic [31:0]      wr_data_i,
  output logic             rd_valid_o,
  input  logic             rd_ready_i,
  output logic [31:0]      rd_data_o,
  output logic             req_o,
  input  logic             gnt_i,
  input  logic             rvalid_i,
  output logic [31:0]      addr_o,
  output logic             we_o,
  output logic [3:0]       be_o,
  output logic [31:0]      wdata_o,
  input  logic [31:0]      rdata_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o,
  output logic [31:0]      stall_cnt_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int PTR_W =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_OUTSTANDING);
  localparam logic [CNT_W:0]   MAX_S = (CNT_W+1)'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] LAST_P = PTR_W'(MAX_OUTSTANDING - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             we_q, we_d;
  logic [LEN_W-1:0] issued_q, issued_d;
  logic [LEN_W-1:0] loaded_q, loaded_d;
  logic [CNT_W-1:0] out_q, out_d;
  logic             hold_v_q, hold_v_d;
  logic [31:0]      hold_q, hold_d;
  logic             err_q, err_d;
  logic             done_q, done_d;
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] fcnt_q, fcnt_d;
  logic [31:0]      mem_q [MAX_OUTSTANDING];

  logic run, cmd_acc, gnt_hs, wr_hs;
  logic rsp_ok, rsp_stray, push, pop;
  logic rd_req, wr_req;

  function automatic logic [PTR_W-1:0] nxt(
    input logic [PTR_W-1:0] p
  );
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  assign run         = state_q == S_RUN;
  assign cmd_ready_o = state_q == S_IDLE;
  assign busy_o      = !cmd_ready_o;
  assign cmd_acc     = cmd_valid_i & cmd_ready_o;

  // Responses with nothing outstanding are stray: dropped, flagged.
  assign rsp_ok    = rvalid_i & (out_q != '0);
  assign rsp_stray = rvalid_i & (out_q == '0);
  assign push      = rsp_ok & !we_q;

  assign rd_valid_o = fcnt_q != '0;
  assign pop        = rd_valid_o & rd_ready_i;
  assign rd_data_o  = rd_valid_o ? mem_q[rptr_q] : '0;

  // Reads reserve FIFO space up front: rvalid cannot be stalled.
  assign rd_req = run & !we_q & (issued_q < len_q) &
                  (({1'b0, out_q} + {1'b0, fcnt_q}) < MAX_S);
  assign wr_req = run & we_q & hold_v_q & (out_q < MAX_C);
  assign req_o  = rd_req | wr_req;
  assign gnt_hs = req_o & gnt_i;

  assign wr_ready_o = run & we_q & (!hold_v_q | gnt_hs) &
                      (loaded_q < len_q);
  assign wr_hs = wr_valid_i & wr_ready_o;

  assign addr_o  = addr_q;
  assign we_o    = we_q;
  assign be_o    = req_o ? 4'hF : 4'h0;
  assign wdata_o = hold_q;
  assign done_o  = done_q;
  assign err_o   = err_q;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    we_d     = we_q;
    issued_d = issued_q;
    loaded_d = loaded_q;
    hold_v_d = hold_v_q;
    hold_d   = hold_q;
    done_d   = 1'b0;
    err_d    = err_q | rsp_stray;

    if (gnt_hs) begin
      addr_d   = addr_q + 32'd4;
      issued_d = issued_q + 1'b1;
    end

    unique case ({gnt_hs, rsp_ok})
      2'b10:   out_d = out_q + 1'b1;
      2'b01:   out_d = out_q - 1'b1;
      default: out_d = out_q;
    endcase

    if (wr_hs) begin
      loaded_d = loaded_q + 1'b1;
      hold_v_d = 1'b1;
      hold_d   = wr_data_i;
    end else if (gnt_hs & we_q) begin
      hold_v_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cmd_acc) begin
          addr_d   = cmd_addr_i & 32'hFFFF_FFFC;
          len_d    = cmd_len_i;
          we_d     = cmd_we_i;
          issued_d = '0;
          loaded_d = '0;
          hold_v_d = 1'b0;
          err_d    = rsp_stray;
          if (cmd_len_i == '0) done_d  = 1'b1;
          else                 state_d = S_RUN;
        end
      end
      // Look at next-cycle counts so done lands right after last rvalid.
      S_RUN: begin
        if (issued_d == len_q) begin
          if (out_d == '0) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (out_d == '0) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    wptr_d = push ? nxt(wptr_q) : wptr_q;
    rptr_d = pop ? nxt(rptr_q) : rptr_q;
    unique case ({push, pop})
      2'b10:   fcnt_d = fcnt_q + 1'b1;
      2'b01:   fcnt_d = fcnt_q - 1'b1;
      default: fcnt_d = fcnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= S_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      we_q     <= 1'b0;
      issued_q <= '0;
      loaded_q <= '0;
      out_q    <= '0;
      hold_v_q <= 1'b0;
      hold_q   <= '0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      fcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      we_q     <= we_d;
      issued_q <= issued_d;
      loaded_q <= loaded_d;
      out_q    <= out_d;
      hold_v_q <= hold_v_d;
      hold_q   <= hold_d;
      err_q    <= err_d;
      done_q   <= done_d;
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      fcnt_q   <= fcnt_d;
    end
  end

  // Storage only; visibility is governed by the reset pointers/count.
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= rdata_i;
  end

`ifdef COREDATA_INIT_STATS_EN
  logic [31:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (cmd_acc)
      stall_d = '0;
    else if (req_o & !gnt_i & (stall_q != '1))
      stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) stall_q <= '0;
    else         stall_q <= stall_d;
  end

  assign stall_cnt_o = stall_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_coredata_initiator.sv
// tb_coredata_initiator: randomized + directed scoreboard bench with a
// bus responder, write-stream driver and read-stream checker.
module tb_coredata_initiator;

  localparam int MO = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid_i = 1'b0;
  logic        cmd_ready_o;
  logic [31:0] cmd_addr_i = '0;
  logic [15:0] cmd_len_i = '0;
  logic        cmd_we_i = 1'b0;
  logic        wr_valid_i = 1'b0;
  logic        wr_ready_o;
  logic [31:0] wr_data_i = '0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic [31:0] rd_data_o;
  logic        req_o;
  logic        gnt_i = 1'b0;
  logic        rvalid_i = 1'b0;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  be_o;
  logic [31:0] wdata_o;
  logic [31:0] rdata_i = '0;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [31:0] stall_cnt_o;

  always #5 clk = ~clk;

  coredata_initiator #(.MAX_OUTSTANDING(MO), .LEN_W(16)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_addr_i(cmd_addr_i), .cmd_len_i(cmd_len_i),
    .cmd_we_i(cmd_we_i),
    .wr_valid_i(wr_valid_i), .wr_ready_o(wr_ready_o),
    .wr_data_i(wr_data_i),
    .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .rd_data_o(rd_data_o),
    .req_o(req_o), .gnt_i(gnt_i), .rvalid_i(rvalid_i),
    .addr_o(addr_o), .we_o(we_o), .be_o(be_o),
    .wdata_o(wdata_o), .rdata_i(rdata_i),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .stall_cnt_o(stall_cnt_o)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [31:0] data;
  } req_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } rsp_t;

  req_t        exp_req_q[$];
  logic [31:0] exp_rd_q[$];
  logic [31:0] wr_q[$];
  rsp_t        rsp_q[$];

  int checks = 0, errors = 0;
  int cyc = 0, done_cnt = 0, gnt_cnt = 0, last_due = 0;
  int gnt_mode = 1, rdy_mode = 1, dly_min = 1, dly_max = 1;
  bit stray_req = 0, len_nz = 0, pend = 0, prev_rv = 0;
  logic [31:0] pend_addr, pend_wdata;
  req_t e;
  int   d;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Memory contents seen by the responder, a pure function of address.
  function automatic logic [31:0] rmodel(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'hC3A5_1E0F;
  endfunction

  function automatic logic pick(input int mode);
    if (mode == 0) return 1'b0;
    if (mode == 1) return 1'b1;
    return $urandom_range(0, 3) != 0;
  endfunction

  // Driver: all random bus/stream inputs change 1 time unit after posedge.
  always @(posedge clk) begin
    cyc++;
    #1;
    gnt_i      = pick(gnt_mode);
    rd_ready_i = pick(rdy_mode);
    if (wr_q.size() > 0 && $urandom_range(0, 3) != 0) begin
      wr_valid_i = 1'b1;
      wr_data_i  = wr_q[0];
    end else begin
      wr_valid_i = 1'b0;
      wr_data_i  = $urandom;
    end
    if (stray_req) begin
      rvalid_i  = 1'b1;
      rdata_i   = $urandom;
      stray_req = 0;
    end else if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
      rvalid_i = 1'b1;
      rdata_i  = rsp_q[0].data;
      void'(rsp_q.pop_front());
    end else begin
      rvalid_i = 1'b0;
      rdata_i  = $urandom;
    end
  end

  // Monitor / scoreboard: evaluates the handshakes of the current cycle.
  always @(negedge clk) begin
    if (!rst_n) begin
      pend = 0;
    end else begin
      if (pend) begin
        chk("req_held", req_o, 1);
        chk("addr_stable", addr_o, pend_addr);
        chk("wdata_stable", wdata_o, pend_wdata);
      end
      if (req_o && gnt_i) begin
        gnt_cnt++;
        if (exp_req_q.size() == 0) begin
          chk("unexpected_req", req_o, 0);
        end else begin
          e = exp_req_q.pop_front();
          chk("addr", addr_o, e.addr);
          chk("we", we_o, e.we);
          chk("be", {28'h0, be_o}, 32'hF);
          if (e.we) chk("wdata", wdata_o, e.data);
          d = cyc + $urandom_range(dly_min, dly_max);
          if (d < last_due) d = last_due;
          last_due = d;
          rsp_q.push_back('{d, e.we ? 32'($urandom) : rmodel(addr_o)});
        end
      end
      pend       = req_o && !gnt_i;
      pend_addr  = addr_o;
      pend_wdata = wdata_o;
      if (wr_valid_i && wr_ready_o && wr_q.size() > 0)
        void'(wr_q.pop_front());
      if (rd_valid_o && rd_ready_i) begin
        if (exp_rd_q.size() == 0)
          chk("unexpected_rd", rd_valid_o, 0);
        else
          chk("rd_data", rd_data_o, exp_rd_q.pop_front());
      end
      if (done_o) begin
        done_cnt++;
        chk("done_cmd_ready", cmd_ready_o, 1);
        if (len_nz) chk("done_after_rvalid", prev_rv, 1);
      end
      prev_rv = rvalid_i;
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_cmd_ready"}, cmd_ready_o, 1);
    chk({tag, "_req"}, req_o, 0);
    chk({tag, "_addr"}, addr_o, 0);
    chk({tag, "_wdata"}, wdata_o, 0);
    chk({tag, "_we_be"}, {27'h0, we_o, be_o}, 0);
    chk({tag, "_wr_ready"}, wr_ready_o, 0);
    chk({tag, "_rd_valid"}, rd_valid_o, 0);
    chk({tag, "_rd_data"}, rd_data_o, 0);
    chk({tag, "_status"}, {29'h0, busy_o, done_o, err_o}, 0);
    chk({tag, "_stall"}, stall_cnt_o, 0);
  endtask

  task automatic run_cmd(input logic [31:0] a, input int len,
                         input logic we, input logic [31:0] wbase);
    int n = 0;
    logic [31:0] wa;
    while (!cmd_ready_o && n < 500) begin
      step();
      n++;
    end
    chk("cmd_ready_wait", cmd_ready_o, 1);
    len_nz = (len != 0);
    for (int i = 0; i < len; i++) begin
      wa = (a & 32'hFFFF_FFFC) + 32'(4 * i);
      if (we) begin
        wr_q.push_back(wbase + 32'(i));
        exp_req_q.push_back('{wa, 1'b1, wbase + 32'(i)});
      end else begin
        exp_req_q.push_back('{wa, 1'b0, 32'h0});
        exp_rd_q.push_back(rmodel(wa));
      end
    end
    cmd_valid_i = 1'b1;
    cmd_addr_i  = a;
    cmd_len_i   = 16'(len);
    cmd_we_i    = we;
    step();
    cmd_valid_i = 1'b0;
    cmd_addr_i  = $urandom;
    cmd_len_i   = 16'($urandom);
    cmd_we_i    = 1'($urandom);
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 500) begin
      step();
      n++;
    end
    chk("done_count", done_cnt - d0, 1);
    chk("req_q_empty", exp_req_q.size(), 0);
    chk("err_clear", err_o, 0);
    chk("idle_busy", busy_o, 0);
  endtask

  task automatic drain_rd();
    int n = 0;
    while (exp_rd_q.size() > 0 && n < 500) begin
      step();
      n++;
    end
    chk("rd_drained", exp_rd_q.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, g0, n;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset("reset");
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    step();

    // Write 4 words at 0x1000, always granted, rvalid one cycle later.
    gnt_mode = 1; rdy_mode = 1; dly_min = 1; dly_max = 1;
    d0 = done_cnt;
    run_cmd(32'h1000, 4, 1'b1, 32'hA0);
    wait_done(d0);

    // Read with rd_ready held low: only MO requests may issue.
    rdy_mode = 0;
    d0 = done_cnt;
    g0 = gnt_cnt;
    run_cmd(32'h1003, 3, 1'b0, 0);
    repeat (12) step();
    chk("rd_limit_gnts", gnt_cnt - g0, MO);
    chk("rd_limit_req", req_o, 0);
    chk("rd_limit_valid", rd_valid_o, 1);
    rdy_mode = 1;
    wait_done(d0);
    drain_rd();

    // Grant withheld for 5 request cycles.
    gnt_mode = 0;
    d0 = done_cnt;
    run_cmd(32'h2000, 1, 1'b1, 32'h5555_0000);
    n = 0;
    @(negedge clk);
    while (!req_o && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("stall_req_seen", req_o, 1);
    repeat (4) @(negedge clk);
    gnt_mode = 1;
    step();
    wait_done(d0);
`ifdef COREDATA_INIT_STATS_EN
    chk("stall_cnt", stall_cnt_o, 5);
`else
    chk("stall_cnt", stall_cnt_o, 0);
`endif

    // Address wrap at the top of the 32-bit space.
    gnt_mode = 2; rdy_mode = 2; dly_min = 1; dly_max = 3;
    d0 = done_cnt;
    run_cmd(32'hFFFF_FFFC, 2, 1'b0, 0);
    wait_done(d0);
    drain_rd();

    // Zero-length transfer.
    gnt_mode = 1;
    d0 = done_cnt;
    g0 = gnt_cnt;
    run_cmd(32'h4000, 0, 1'b1, 0);
    chk("len0_done", done_o, 1);
    step();
    chk("len0_done_pulse", done_o, 0);
    chk("len0_done_count", done_cnt - d0, 1);
    chk("len0_no_req", gnt_cnt - g0, 0);

    // Stray response in IDLE sets a sticky error.
    stray_req = 1;
    step();
    step();
    chk("stray_err", err_o, 1);
    repeat (3) step();
    chk("stray_err_sticky", err_o, 1);
    d0 = done_cnt;
    run_cmd(32'h4100, 0, 1'b0, 0);
    wait_done(d0);

    // Randomized transfers.
    for (int t = 0; t < 25; t++) begin
      gnt_mode = 2; rdy_mode = 2; dly_min = 1; dly_max = 3;
      d0 = done_cnt;
      run_cmd($urandom, $urandom_range(0, 8),
              1'($urandom_range(0, 1)), $urandom);
      wait_done(d0);
      drain_rd();
    end

    // Reset with two reads outstanding.
    gnt_mode = 1; rdy_mode = 0; dly_min = 3; dly_max = 3;
    g0 = gnt_cnt;
    run_cmd(32'h3000, 4, 1'b0, 0);
    n = 0;
    while (gnt_cnt - g0 < 2 && n < 50) begin
      step();
      n++;
    end
    chk("rst_two_out", gnt_cnt - g0, 2);
    rst_n = 1'b0;
    exp_req_q.delete();
    exp_rd_q.delete();
    rsp_q.delete();
    wr_q.delete();
    stray_req = 0;
    #1;
    chk_reset("midrst");
    step();
    rst_n = 1'b1;
    step();
    rdy_mode = 1; dly_min = 1; dly_max = 1;
    d0 = done_cnt;
    run_cmd(32'h5000, 1, 1'b0, 0);
    wait_done(d0);
    drain_rd();

    repeat (3) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
